io_uart_bridge: RTL

//  Off-core end of the CPU 16-bit I/O ports: serializes each word the CPU writes via OUT onto a UART
//  tx line and deserializes words from a UART rx line into the value the CPU samples with IN.

---
 rtl/io_uart_bridge.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/io_uart_bridge.sv
// Off-core end of the CPU 16-bit I/O ports: OUT words are queued and sent as two 8N1 frames
// (low byte first); pairs of received 8N1 frames are assembled into the word the CPU reads with IN.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  TX_IDLE  | line high; pops the next word when the FIFO is non-empty
//  TX_START | start bit of the current byte
//  TX_DATA  | 8 data bits, LSB first
//  TX_STOP  | stop bit; continues with high byte or returns to idle
//  RX_IDLE  | waiting for rx_s to fall
//  RX_START | half-bit wait, then confirm start bit (glitch reject)
//  RX_DATA  | sample 8 data bits at bit centres, LSB first
//  RX_STOP  | sample stop bit; commit byte / word or flag framing error
module io_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] out_data,
  input  logic        out_load,
  output logic [15:0] in_data,
  output logic        in_valid,
  output logic        tx,
  input  logic        rx,
  output logic        tx_busy,
  output logic        tx_ovf,
  output logic        rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] fifo_cnt;
  logic          fifo_full, push, pop;

  assign fifo_full = (fifo_cnt == NW'(FIFO_DEPTH));
  assign push      = out_load && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= out_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + NW'(push) - NW'(pop);
      if (out_load && fifo_full) tx_ovf <= 1'b1;
    end
  end

  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic          tx_hi, tx_hi_n, tx_n;
  logic [15:0]   tx_word, tx_word_n;
  logic [7:0]    tx_byte;

  assign tx_byte = tx_hi ? tx_word[15:8] : tx_word[7:0];
  assign tx_busy = (fifo_cnt != '0) || (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_hi    <= 1'b0;
      tx_word  <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_hi    <= tx_hi_n;
      tx_word  <= tx_word_n;
      tx       <= tx_n;
    end
  end

  // tx is computed from the next state so the line and state register change on the same edge
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_hi_n    = tx_hi;
    tx_word_n  = tx_word;
    tx_n       = tx;
    pop        = 1'b0;
    case (tx_state)
      TX_IDLE: if (fifo_cnt != '0) begin
        pop        = 1'b1;
        tx_word_n  = fifo_mem[rd_ptr];
        tx_hi_n    = 1'b0;
        tx_cnt_n   = BIT_LAST;
        tx_n       = 1'b0;
        tx_state_n = TX_START;
      end
      TX_START: if (tx_cnt == '0) begin
        tx_cnt_n   = BIT_LAST;
        tx_bit_n   = '0;
        tx_n       = tx_byte[0];
        tx_state_n = TX_DATA;
      end else tx_cnt_n = tx_cnt - CW'(1);
      TX_DATA: if (tx_cnt == '0) begin
        tx_cnt_n = BIT_LAST;
        if (tx_bit == 3'd7) begin
          tx_n       = 1'b1;
          tx_state_n = TX_STOP;
        end else begin
          tx_bit_n = tx_bit + 3'd1;
          tx_n     = tx_byte[tx_bit + 3'd1];
        end
      end else tx_cnt_n = tx_cnt - CW'(1);
      TX_STOP: if (tx_cnt == '0) begin
        if (!tx_hi) begin
          tx_hi_n    = 1'b1;
          tx_cnt_n   = BIT_LAST;
          tx_n       = 1'b0;
          tx_state_n = TX_START;
        end else tx_state_n = TX_IDLE;
      end else tx_cnt_n = tx_cnt - CW'(1);
      default: tx_state_n = TX_IDLE;
    endcase
  end

  logic          rx_meta, rx_s;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n, rx_lo, rx_lo_n;
  logic          rx_hi, rx_hi_n;
  logic [15:0]   in_data_n;
  logic          in_valid_n, rx_ferr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_lo    <= '0;
      rx_hi    <= 1'b0;
      in_data  <= '0;
      in_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_lo    <= rx_lo_n;
      rx_hi    <= rx_hi_n;
      in_data  <= in_data_n;
      in_valid <= in_valid_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_lo_n    = rx_lo;
    rx_hi_n    = rx_hi;
    in_data_n  = in_data;
    in_valid_n = 1'b0;
    rx_ferr_n  = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_s) begin
        rx_cnt_n   = HALF_LAST;
        rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == '0) begin
        rx_cnt_n   = BIT_LAST;
        rx_bit_n   = '0;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end else rx_cnt_n = rx_cnt - CW'(1);
      RX_DATA: if (rx_cnt == '0) begin
        rx_sh_n  = {rx_s, rx_sh[7:1]};
        rx_cnt_n = BIT_LAST;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        else rx_bit_n = rx_bit + 3'd1;
      end else rx_cnt_n = rx_cnt - CW'(1);
      RX_STOP: if (rx_cnt == '0) begin
        rx_state_n = RX_IDLE;
        rx_hi_n    = 1'b0;
        if (!rx_s) rx_ferr_n = 1'b1;
        else if (!rx_hi) begin
          rx_lo_n = rx_sh;
          rx_hi_n = 1'b1;
        end else begin
          in_data_n  = {rx_sh, rx_lo};
          in_valid_n = 1'b1;
        end
      end else rx_cnt_n = rx_cnt - CW'(1);
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule
